memoria_dados_espera: RTL and testbench

Parametrised data memory for the nRisc datapath, replacing the fixed 8-bit × 256 combined-edge memory with a single-edge, request/ready memory. Word width, depth and access latency are configurable, and a post-reset clear sweep zeroes the array. The block sits between the datapath's memory-stage control signals and the register-file write-back mux. The control unit stalls on `Pronto` and captures data on `Valido`.

---
 rtl/memoria_dados_espera.sv | 127 ++++++++++++
 tb/tb_memoria_dados_espera.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/memoria_dados_espera.sv
// memoria_dados_espera: single-edge data memory with a request/ready handshake.
// A request is accepted only when Pronto is high. Each accepted request
// completes LATENCIA edges later with a one-cycle Valido pulse.
// After reset, an optional clear sweep zeroes every word before the first
// request is accepted.
module memoria_dados_espera #(
  parameter int LARGURA        = 8,
  parameter int PROF_BITS      = 8,
  parameter int LATENCIA       = 2,
  parameter bit LIMPA_NO_RESET = 1'b1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 EscMem,
  input  logic                 LerMem,
  input  logic [PROF_BITS-1:0] Endereco,
  input  logic [LARGURA-1:0]   DadoEscrito,
  output logic [LARGURA-1:0]   DadoLido,
  output logic                 Pronto,
  output logic                 Valido
);

  typedef enum logic [1:0] {
    LIMPANDO = 2'd0,
    OCIOSO   = 2'd1,
    ESPERA   = 2'd2
  } estado_t;

  localparam int                   PROFUNDIDADE    = 2 ** PROF_BITS;
  localparam estado_t              LC_ESTADO_RESET = LIMPA_NO_RESET ? LIMPANDO : OCIOSO;
  localparam logic [3:0]           LC_ESPERA_INI   = 4'(LATENCIA - 1);
  localparam logic [PROF_BITS-1:0] LC_ULTIMO       = '1;

  estado_t                r_estado;
  estado_t                w_prox_estado;
  logic [PROF_BITS-1:0]   r_varredura;
  logic [3:0]             r_espera;
  logic [PROF_BITS-1:0]   r_end;
  logic [LARGURA-1:0]     r_dado;
  logic                   r_escrita;
  logic                   r_valido;
  logic [LARGURA-1:0]     r_dado_lido;
  logic [LARGURA-1:0]     r_mem [PROFUNDIDADE];

  logic                   w_aceita;
  logic                   w_conclui;
  logic                   w_mem_we;
  logic [PROF_BITS-1:0]   w_mem_end;
  logic [LARGURA-1:0]     w_mem_dado;

  // A request is accepted only while idle. When both request lines are high,
  // the op is latched as a write.
  assign w_aceita  = (r_estado == OCIOSO) && (EscMem || LerMem);
  assign w_conclui = (r_estado == ESPERA) && (r_espera == 4'd0);

  assign DadoLido  = r_dado_lido;
  assign Valido    = r_valido;

  // State register. Reset drops straight into the sweep, or into idle when the sweep is disabled.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_estado <= LC_ESTADO_RESET;
    else       r_estado <= w_prox_estado;
  end

  // Next-state logic: the sweep ends on the last index, and the wait ends on completion.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_prox_estado = r_estado;
    unique case (r_estado)
      LIMPANDO: if (r_varredura == LC_ULTIMO) w_prox_estado = OCIOSO;
      OCIOSO:   if (w_aceita)                 w_prox_estado = ESPERA;
      ESPERA:   if (w_conclui)                w_prox_estado = OCIOSO;
      default:                                w_prox_estado = LC_ESTADO_RESET;
    endcase
  end

  // Output logic: ready flag, plus the single memory write port shared by the sweep and completed writes.
  always_comb begin
    Pronto     = 1'b0;
    w_mem_we   = 1'b0;
    w_mem_end  = r_end;
    w_mem_dado = r_dado;
    unique case (r_estado)
      LIMPANDO: begin
        w_mem_we   = 1'b1;
        w_mem_end  = r_varredura;
        w_mem_dado = '0;
      end
      OCIOSO:   Pronto   = 1'b1;
      ESPERA:   w_mem_we = w_conclui && r_escrita;
      default:  Pronto   = 1'b0;
    endcase
  end

  // Datapath registers: sweep index, wait countdown, latched request and completion outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_varredura <= '0;
      r_espera    <= 4'd0;
      r_end       <= '0;
      r_dado      <= '0;
      r_escrita   <= 1'b0;
      r_valido    <= 1'b0;
      r_dado_lido <= '0;
    end else begin
      r_valido <= w_conclui;
      if (r_estado == LIMPANDO) r_varredura <= r_varredura + 1'b1;
      if (w_aceita) begin
        r_end     <= Endereco;
        r_dado    <= DadoEscrito;
        r_escrita <= EscMem;
        r_espera  <= LC_ESPERA_INI;
      end else if ((r_estado == ESPERA) && (r_espera != 4'd0)) begin
        r_espera <= r_espera - 4'd1;
      end
      if (w_conclui && !r_escrita) r_dado_lido <= r_mem[r_end];
    end
  end

  // Storage array. It has a single write port, driven by the sweep or by a completed write.
  // NOTE: the array has no reset; clearing it is the sweep's job, so reset does not fan out to every word.
  always_ff @(posedge Clock) begin
    if (w_mem_we) r_mem[w_mem_end] <= w_mem_dado;
  end

endmodule

// File: tb/tb_memoria_dados_espera.sv
// Directed bench for memoria_dados_espera covering the default configuration
// (8/8/2/1), a 16-bit latency-1 variant, and a variant without the clear sweep.
module tb_memoria_dados_espera;

  logic        clk;
  logic        rst, esc, ler;
  logic [7:0]  addr, din, dout;
  logic        pronto, valido;

  logic        rst16, esc16, ler16;
  logic [7:0]  addr16;
  logic [15:0] din16, dout16, dout_nc;
  logic        pronto16, valido16, pronto_nc, valido_nc;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  memoria_dados_espera dut (
    .Clock(clk), .Reset(rst), .EscMem(esc), .LerMem(ler), .Endereco(addr),
    .DadoEscrito(din), .DadoLido(dout), .Pronto(pronto), .Valido(valido)
  );

  memoria_dados_espera #(.LARGURA(16), .PROF_BITS(8), .LATENCIA(1), .LIMPA_NO_RESET(1'b1)) dut16 (
    .Clock(clk), .Reset(rst16), .EscMem(esc16), .LerMem(ler16), .Endereco(addr16),
    .DadoEscrito(din16), .DadoLido(dout16), .Pronto(pronto16), .Valido(valido16)
  );

  memoria_dados_espera #(.LARGURA(16), .PROF_BITS(8), .LATENCIA(1), .LIMPA_NO_RESET(1'b0)) dut_nc (
    .Clock(clk), .Reset(rst16), .EscMem(esc16), .LerMem(ler16), .Endereco(addr16),
    .DadoEscrito(din16), .DadoLido(dout_nc), .Pronto(pronto_nc), .Valido(valido_nc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  function automatic logic get_pronto(input bit big);
    return big ? pronto16 : pronto;
  endfunction

  function automatic logic get_valido(input bit big);
    return big ? valido16 : valido;
  endfunction

  task automatic drive(input bit big, input bit w, input bit r, input logic [7:0] a, input logic [15:0] d);
    if (big) begin
      esc16 = w; ler16 = r; addr16 = a; din16 = d;
    end else begin
      esc = w; ler = r; addr = a; din = d[7:0];
    end
  endtask

  // Counts the cycles Pronto stays low after reset release (bounded).
  task automatic wait_sweep(input bit big, input string tag);
    int low;
    low = 0;
    while (get_pronto(big) !== 1'b1 && low < 300) begin
      low++;
      tick();
    end
    check(tag, low, 256);
  endtask

  // Issues one request and returns at the completion sample (Valido high).
  task automatic op(input bit big, input bit w, input bit r, input logic [7:0] a,
                    input logic [15:0] d, input bit noise, input int exp_lat,
                    input string tag, output int acc_cycle);
    int k;
    check({tag, "_pronto_pre"}, get_pronto(big), 1);
    drive(big, w, r, a, d);
    tick();
    acc_cycle = cycle;
    check({tag, "_pronto_busy"}, get_pronto(big), 0);
    check({tag, "_valido_low"}, get_valido(big), 0);
    k = 0;
    if (noise) begin
      drive(big, 1'b0, 1'b1, 8'h40, 16'h00FF);
      tick();
      k = 1;
    end
    drive(big, 1'b0, 1'b0, 8'h00, 16'h0000);
    while (get_valido(big) !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_latency"}, k, exp_lat);
    check({tag, "_pronto_done"}, get_pronto(big), 1);
  endtask

  initial begin
    int a0, a1, extra_v, extra_p;
    rst = 1'b0; esc = 1'b0; ler = 1'b0; addr = 8'h00; din = 8'h00;
    rst16 = 1'b0; esc16 = 1'b0; ler16 = 1'b0; addr16 = 8'h00; din16 = 16'h0000;

    // Asynchronous reset, applied before any clock edge
    #1 rst = 1'b1; rst16 = 1'b1;
    #1;
    check("rst_pronto", pronto, 0);
    check("rst_valido", valido, 0);
    check("rst_dout", dout, 8'h00);
    check("rst_nc_pronto", pronto_nc, 1);
    check("rst_16_pronto", pronto16, 0);
    tick();
    rst = 1'b0;

    // Clear sweep: 256 cycles of Pronto low
    wait_sweep(1'b0, "sweep_len");

    // Read of a cleared word
    op(1'b0, 1'b0, 1'b1, 8'h7F, 16'h0000, 1'b0, 2, "rd7f", a0);
    check("rd7f_data", dout, 8'h00);

    // Write then read, back to back
    op(1'b0, 1'b1, 1'b0, 8'h10, 16'h00A5, 1'b0, 2, "wr10", a0);
    op(1'b0, 1'b0, 1'b1, 8'h10, 16'h0000, 1'b0, 2, "rd10", a1);
    check("rd10_data", dout, 8'hA5);
    check("spacing_lat2", a1 - a0, 3);

    // Simultaneous request: write wins, and the read data is left alone
    op(1'b0, 1'b1, 1'b1, 8'h20, 16'h003C, 1'b0, 2, "both20", a0);
    check("both20_dout_kept", dout, 8'hA5);
    op(1'b0, 1'b0, 1'b1, 8'h20, 16'h0000, 1'b0, 2, "rd20", a0);
    check("rd20_data", dout, 8'h3C);

    // Input changes during ESPERA are ignored
    op(1'b0, 1'b0, 1'b1, 8'h10, 16'h0000, 1'b1, 2, "rd10_noise", a0);
    check("rd10_noise_data", dout, 8'hA5);
    extra_v = 0;
    extra_p = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valido !== 1'b0) extra_v++;
      if (pronto !== 1'b1) extra_p++;
    end
    check("noise_no_extra_valido", extra_v, 0);
    check("noise_no_second_op", extra_p, 0);
    check("noise_dout_hold", dout, 8'hA5);

    // Reset in the middle of a pending write
    drive(1'b0, 1'b1, 1'b0, 8'h30, 16'h0055);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    check("midwr_busy", pronto, 0);
    tick();
    rst = 1'b1;
    #1;
    check("midwr_pronto", pronto, 0);
    check("midwr_valido", valido, 0);
    check("midwr_dout", dout, 8'h00);
    tick();
    rst = 1'b0;
    wait_sweep(1'b0, "midwr_sweep_len");
    op(1'b0, 1'b0, 1'b1, 8'h30, 16'h0000, 1'b0, 2, "rd30", a0);
    check("rd30_data", dout, 8'h00);
    tick();
    check("rd30_pulse_end", valido, 0);

    // Variants: 16-bit, latency 1, with and without the sweep
    check("v16_rst_dout", dout16, 16'h0000);
    rst16 = 1'b0;
    check("nc_pronto_first", pronto_nc, 1);
    wait_sweep(1'b1, "v16_sweep_len");
    op(1'b1, 1'b1, 1'b0, 8'hFF, 16'hBEEF, 1'b0, 1, "v16_wrff", a0);
    op(1'b1, 1'b0, 1'b1, 8'hFF, 16'h0000, 1'b0, 1, "v16_rdff", a1);
    check("v16_rdff_data", dout16, 16'hBEEF);
    check("v16_spacing", a1 - a0, 2);
    check("nc_valido", valido_nc, 1);
    check("nc_rdff_data", dout_nc, 16'hBEEF);
    tick();
    check("v16_pulse_end", valido16, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
